// File: rtl/fp_wb_pkg.sv
// Shared types and default sizes for the FP register writeback arbiter.
package fp_wb_pkg;

    localparam int unsigned WB_DEPTH = 4;
    localparam int unsigned WB_DW    = 32;
    localparam int unsigned WB_AW    = 5;
    localparam int unsigned CNT_W    = $clog2(WB_DEPTH) + 1;

    typedef struct packed {
        logic [WB_AW-1:0] n;
        logic [WB_DW-1:0] d;
    } wb_entry_t;

endpackage

// File: rtl/fp_wb_queue.sv
// In-order 2-push/1-pop circular buffer of pending FP register writes with
// two youngest-match lookup ports.
module fp_wb_queue
    import fp_wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned DW    = WB_DW,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push0,
    input  logic [AW-1:0] push0_n,
    input  logic [DW-1:0] push0_d,
    input  logic          push1,
    input  logic [AW-1:0] push1_n,
    input  logic [DW-1:0] push1_d,
    input  logic          pop,
    output logic [AW-1:0] head_n,
    output logic [DW-1:0] head_d,
    output logic [CW-1:0] cnt,
    input  logic [AW-1:0] qa_n,
    input  logic [AW-1:0] qb_n,
    output logic          qa_hit,
    output logic [DW-1:0] qa_d,
    output logic          qb_hit,
    output logic [DW-1:0] qb_d
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] n_mem [DEPTH];
    logic [DW-1:0] d_mem [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] tail_p1;

    assign tail_p1 = tail_q + PW'(1);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push0) begin
                n_mem[tail_q] <= push0_n;
                d_mem[tail_q] <= push0_d;
            end
            // The second push lands behind the first so age order is kept.
            if (push1) begin
                n_mem[push0 ? tail_p1 : tail_q] <= push1_n;
                d_mem[push0 ? tail_p1 : tail_q] <= push1_d;
            end
            tail_q <= tail_q + PW'(push0) + PW'(push1);
            head_q <= head_q + PW'(pop);
            cnt_q  <= cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign head_n = n_mem[head_q];
    assign head_d = d_mem[head_q];
    assign cnt    = cnt_q;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        qa_hit = 1'b0;
        qa_d   = '0;
        qb_hit = 1'b0;
        qb_d   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q) begin
                if (n_mem[head_q + PW'(i)] == qa_n) begin
                    qa_hit = 1'b1;
                    qa_d   = d_mem[head_q + PW'(i)];
                end
                if (n_mem[head_q + PW'(i)] == qb_n) begin
                    qb_hit = 1'b1;
                    qb_d   = d_mem[head_q + PW'(i)];
                end
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Merges FPU and lwc1 register writes onto one FPR write port, queueing the
// losing write and stalling the IU before the queue can overflow.
module fp_wb_arbiter
    import fp_wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned DW    = WB_DW,
    parameter int unsigned AW    = WB_AW
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [DW-1:0]            fwd,
    input  logic [AW-1:0]            fwn,
    input  logic                     fww,
    input  logic [DW-1:0]            lwd,
    input  logic [AW-1:0]            lwn,
    input  logic                     lww,
    output logic [DW-1:0]            wr_d,
    output logic [AW-1:0]            wr_n,
    output logic                     wr_we,
    input  logic [AW-1:0]            qa_n,
    input  logic [AW-1:0]            qb_n,
    output logic                     qa_hit,
    output logic [DW-1:0]            qa_d,
    output logic                     qb_hit,
    output logic [DW-1:0]            qb_d,
    output logic                     stl_wb,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     ovf
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] head_n;
    logic [DW-1:0] head_d;
    logic          pop, fpu_direct, lw_direct;
    logic          push0_req, push1_req, push0, push1;
    logic          full, drop;
    logic [CW-1:0] cnt_next;
    logic          stl_q, ovf_q;

    always_comb begin
        wr_we      = 1'b0;
        wr_n       = '0;
        wr_d       = '0;
        pop        = 1'b0;
        fpu_direct = 1'b0;
        lw_direct  = 1'b0;
        if (clrn) begin
            if (cnt != '0) begin
                wr_we = 1'b1;
                wr_n  = head_n;
                wr_d  = head_d;
                pop   = 1'b1;
            end else if (fww) begin
                wr_we      = 1'b1;
                wr_n       = fwn;
                wr_d       = fwd;
                fpu_direct = 1'b1;
            end else if (lww) begin
                wr_we     = 1'b1;
                wr_n      = lwn;
                wr_d      = lwd;
                lw_direct = 1'b1;
            end
        end
    end

    // Below full there is always room for two pushes (a pop frees a slot
    // whenever the queue is non-empty); at full every push is dropped.
    assign push0_req = clrn && fww && !fpu_direct;
    assign push1_req = clrn && lww && !lw_direct;
    assign full      = (cnt == CW'(DEPTH));
    assign drop      = full && (push0_req || push1_req);
    assign push0     = push0_req && !full;
    assign push1     = push1_req && !full;
    assign cnt_next  = cnt + CW'(push0) + CW'(push1) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            stl_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            stl_q <= (cnt_next >= CW'(DEPTH - 1));
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign stl_wb = stl_q;
    assign ovf    = ovf_q;

    fp_wb_queue #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW),
        .CW    (CW)
    ) u_queue (
        .clk     (clk),
        .clrn    (clrn),
        .push0   (push0),
        .push0_n (fwn),
        .push0_d (fwd),
        .push1   (push1),
        .push1_n (lwn),
        .push1_d (lwd),
        .pop     (pop),
        .head_n  (head_n),
        .head_d  (head_d),
        .cnt     (cnt),
        .qa_n    (qa_n),
        .qb_n    (qb_n),
        .qa_hit  (qa_hit),
        .qa_d    (qa_d),
        .qb_hit  (qb_hit),
        .qb_d    (qb_d)
    );

endmodule
